// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// instruction fetch (read-only) and a data/loader port (read/write, byte enables).
module imem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                f_req_valid,
    output logic                f_req_ready,
    input  logic [ADDR_W-1:0]   f_addr,
    output logic                f_rvalid,
    output logic [DATA_W-1:0]   f_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int          BE_W = DATA_W / 8;
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                last_d_q, last_d_d;   // 1: data port won the last grant
    logic                port_d_q, port_d_d;   // 1: captured request belongs to data port
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                f_rvalid_q, f_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant_f, grant_d;

    // On a tie the port that did not win last time gets the grant
    assign grant_f = f_req_valid && (!d_req_valid || last_d_q);
    assign grant_d = d_req_valid && (!f_req_valid || !last_d_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        port_d_d    = port_d_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        f_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        f_req_ready = 1'b0;
        d_req_ready = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;

        unique case (state_q)
            S_IDLE: begin
                f_req_ready = grant_f;
                d_req_ready = grant_d;
                if (grant_f) begin
                    addr_d   = f_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    be_d     = '1;
                    port_d_d = 1'b0;
                    last_d_d = 1'b0;
                    state_d  = S_ISSUE;
                end else if (grant_d) begin
                    addr_d   = d_addr;
                    we_d     = d_we;
                    wdata_d  = d_wdata;
                    be_d     = d_be;
                    port_d_d = 1'b1;
                    last_d_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_be    = be_q;
                cnt_d     = LAT;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                    if (port_d_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = we_q ? '0 : mem_rdata;
                    end else begin
                        f_rvalid_d = 1'b1;
                        f_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            last_d_q   <= 1'b1;
            port_d_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_d_q   <= last_d_d;
            port_d_q   <= port_d_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f_rvalid_q <= f_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign f_rvalid = f_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign f_rdata  = f_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a LATENCY=1 instance with a behavioural
// memory and a LATENCY=3 instance with a three-stage read pipeline.
module tb_imem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req_valid, f_req_ready, f_rvalid;
    logic [9:0]  f_addr;
    logic [31:0] f_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_rvalid;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        g_f_valid, g_f_ready, g_f_rvalid;
    logic [9:0]  g_f_addr;
    logic [31:0] g_f_rdata;
    logic        g_d_ready, g_d_rvalid;
    logic [31:0] g_d_rdata;
    logic        g_mem_en, g_mem_we, g_busy;
    logic [9:0]  g_mem_addr;
    logic [31:0] g_mem_wdata, g_mem_rdata;
    logic [3:0]  g_mem_be;
    logic [31:0] g_p1, g_p2;

    logic [31:0] mem1 [0:1023];
    int          n_vec = 0;
    int          n_err = 0;

    imem_arbiter #(.ADDR_W(10), .DATA_W(32), .LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    imem_arbiter #(.ADDR_W(10), .DATA_W(32), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .f_req_valid(g_f_valid), .f_req_ready(g_f_ready), .f_addr(g_f_addr),
        .f_rvalid(g_f_rvalid), .f_rdata(g_f_rdata),
        .d_req_valid(1'b0), .d_req_ready(g_d_ready), .d_we(1'b0),
        .d_addr(10'd0), .d_wdata(32'd0), .d_be(4'd0),
        .d_rvalid(g_d_rvalid), .d_rdata(g_d_rdata),
        .mem_en(g_mem_en), .mem_we(g_mem_we), .mem_addr(g_mem_addr),
        .mem_wdata(g_mem_wdata), .mem_be(g_mem_be), .mem_rdata(g_mem_rdata),
        .busy(g_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory, one-cycle registered read, byte-enabled write
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem1[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem1[mem_addr];
            end
        end
    end

    // Three-cycle read pipeline; data appears for exactly one cycle
    always @(posedge clk) begin
        g_p1        <= (g_mem_en && !g_mem_we && g_mem_addr == 10'd4) ? 32'hCAFEF00D : 32'd0;
        g_p2        <= g_p1;
        g_mem_rdata <= g_p2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        f_req_valid = 1'b0; f_addr = '0;
        d_req_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        g_f_valid = 1'b0; g_f_addr = '0;
        mem_rdata = '0;
        for (int i = 0; i < 1024; i++) mem1[i] = 32'hFFFFFFFF;
        mem1[4]  = 32'h00500093;
        mem1[0]  = 32'h11111111;
        mem1[16] = 32'h22222222;

        // Reset state
        step();
        chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_mem_en",   32'(mem_en), 32'd0);
        chk("rst_mem_we",   32'(mem_we), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_f_rdata",  f_rdata, 32'd0);
        chk("rst_d_rdata",  d_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_be",   32'(mem_be), 32'd0);
        step();
        rst = 1'b1;

        // Single fetch, LATENCY=1
        f_req_valid = 1'b1; f_addr = 10'h004;
        #1;
        chk("t1_f_ready", 32'(f_req_ready), 32'd1);
        chk("t1_d_ready", 32'(d_req_ready), 32'd0);
        chk("t1_busy0",   32'(busy), 32'd0);
        step();
        f_req_valid = 1'b0;
        #1;
        chk("t1_mem_en",   32'(mem_en), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h004);
        chk("t1_mem_we",   32'(mem_we), 32'd0);
        chk("t1_mem_be",   32'(mem_be), 32'hF);
        chk("t1_busy1",    32'(busy), 32'd1);
        step(); #1;
        chk("t1_busy2",   32'(busy), 32'd1);
        chk("t1_mem_en2", 32'(mem_en), 32'd0);
        chk("t1_rv_early", 32'(f_rvalid), 32'd0);
        step(); #1;
        chk("t1_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("t1_f_rdata",  f_rdata, 32'h00500093);
        chk("t1_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("t1_busy3",    32'(busy), 32'd0);
        step(); #1;
        chk("t1_rv_pulse", 32'(f_rvalid), 32'd0);
        chk("t1_rdata_hold", f_rdata, 32'h00500093);

        // Contention after reset: F, D, F, D
        rst = 1'b0;
        step();
        rst = 1'b1;
        f_req_valid = 1'b1; f_addr = 10'h000;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 10'h010; d_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_f_ready", 32'(f_req_ready), 32'(i % 2 == 0));
            chk("rr_d_ready", 32'(d_req_ready), 32'(i % 2 == 1));
            if (i > 0) begin
                chk("rr_f_rvalid", 32'(f_rvalid), 32'(i % 2 == 1));
                chk("rr_d_rvalid", 32'(d_rvalid), 32'(i % 2 == 0));
            end
            step(); #1;
            chk("rr_issue_rdy", 32'({f_req_ready, d_req_ready}), 32'd0);
            chk("rr_mem_addr",  32'(mem_addr), (i % 2 == 0) ? 32'h000 : 32'h010);
            step();
            step();
        end
        #1;
        chk("rr_last_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("rr_last_d_rdata",  d_rdata, 32'h22222222);
        chk("rr_last_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rr_f_rdata_hold",  f_rdata, 32'h11111111);
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        step();

        // Byte-enabled write, read-back, fetch accepted alongside d_rvalid
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        #1;
        chk("wr_d_ready", 32'(d_req_ready), 32'd1);
        step();
        d_req_valid = 1'b0;
        #1;
        chk("wr_mem_en",    32'(mem_en), 32'd1);
        chk("wr_mem_we",    32'(mem_we), 32'd1);
        chk("wr_mem_be",    32'(mem_be), 32'h3);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_mem_addr",  32'(mem_addr), 32'h020);
        step(); step();
        d_req_valid = 1'b1; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
        #1;
        chk("wr_ack",       32'(d_rvalid), 32'd1);
        chk("wr_ack_rdata", d_rdata, 32'd0);
        chk("rd_d_ready",   32'(d_req_ready), 32'd1);
        step();
        d_req_valid = 1'b0;
        #1;
        chk("rd_mem_en", 32'(mem_en), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        step(); step();
        f_req_valid = 1'b1; f_addr = 10'h004;
        #1;
        chk("rd_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("rd_d_rdata",  d_rdata, 32'hFFFFBEEF);
        chk("bb_f_ready",  32'(f_req_ready), 32'd1);
        step();
        f_req_valid = 1'b0;
        #1;
        chk("bb_mem_en",   32'(mem_en), 32'd1);
        chk("bb_mem_addr", 32'(mem_addr), 32'h004);
        step(); step(); #1;
        chk("bb_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("bb_f_rdata",  f_rdata, 32'h00500093);

        // Asynchronous reset during WAIT
        step();
        f_req_valid = 1'b1; f_addr = 10'h000;
        step();
        f_req_valid = 1'b0;
        step(); #1;
        chk("ar_busy_wait", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("ar_busy",    32'(busy), 32'd0);
        chk("ar_f_rdata", f_rdata, 32'd0);
        chk("ar_d_rdata", d_rdata, 32'd0);
        chk("ar_outs",    32'({f_rvalid, d_rvalid, mem_en, mem_we}), 32'd0);
        step(); step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ar_no_rvalid", 32'(f_rvalid), 32'd0);
        end
        f_req_valid = 1'b1; f_addr = 10'h004;
        #1;
        chk("ar_f_ready", 32'(f_req_ready), 32'd1);
        step();
        f_req_valid = 1'b0;
        step(); step(); #1;
        chk("ar_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("ar_f_rdata2", f_rdata, 32'h00500093);

        // LATENCY=3 instance: response exactly at t+5
        step();
        g_f_valid = 1'b1; g_f_addr = 10'h004;
        #1;
        chk("l3_ready_t", 32'(g_f_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("l3_ready_busy", 32'(g_f_ready), 32'd0);
            chk("l3_mem_en",     32'(g_mem_en), 32'(k == 1));
            chk("l3_no_rvalid",  32'(g_f_rvalid), 32'd0);
        end
        step();
        chk("l3_f_rvalid", 32'(g_f_rvalid), 32'd1);
        chk("l3_f_rdata",  g_f_rdata, 32'hCAFEF00D);
        chk("l3_busy",     32'(g_busy), 32'd0);
        g_f_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
